// File: rtl/decode3_register_bank_pkg.sv
// decode3_register_bank_pkg: shared sizes for the decoded register bank
package decode3_register_bank_pkg;
  localparam int NUM_REGS = 8;
  localparam int SEL_W = 3;
  localparam int DATA_W = 8;
endpackage

// File: rtl/decode3_register_bank_decode_3to8.sv
// decode_3to8: one-hot 3-to-8 decoder with enable
module decode_3to8 (
  input  logic [2:0] de_in,
  input  logic       en,
  output logic [7:0] de_out
);
  always_comb de_out = en ? 8'b1 << de_in : '0;
endmodule

// File: rtl/decode3_register_bank.sv
// decode3_register_bank: bank of N W-bit registers written via a 3-to-8 decode
module decode3_register_bank
  import decode3_register_bank_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int N = NUM_REGS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] sel,
  input  logic [W-1:0]     wd,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [W-1:0]     rd_data,
  output logic [N*W-1:0]   rd_all,
  output logic [7:0]       dec_out
);
  decode_3to8 u_dec (.de_in(sel), .en(wr_en), .de_out(dec_out));
  for (genvar i = 0; i < N; i++) begin : g_reg
    logic [W-1:0] q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (dec_out[i]) q <= wd;
    assign rd_all[i*W +: W] = q;
  end
  assign rd_data = rd_all[rd_sel*W +: W];
endmodule

// File: tb/tb_decode3_register_bank.sv
// tb_decode3_register_bank: directed scoreboard bench for the decoded register bank
module tb_decode3_register_bank;
  localparam int W = 8;
  logic clk = 0;
  logic rst_n, wr_en;
  logic [2:0] sel, rd_sel;
  logic [W-1:0] wd, rd_data;
  logic [8*W-1:0] rd_all;
  logic [7:0] dec_out;
  int n_cmp = 0, n_err = 0;
  logic [63:0] sb[$];
  logic [W-1:0] mdl [8];

  always #5 clk = ~clk;

  decode3_register_bank #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .sel(sel), .wd(wd),
    .rd_sel(rd_sel), .rd_data(rd_data), .rd_all(rd_all), .dec_out(dec_out)
  );

  task automatic push(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  function automatic logic [63:0] packm();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*W +: W] = mdl[i];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    rst_n = 0; wr_en = 1; sel = 3'd4; wd = '0; rd_sel = '0;
    #3;
    push(64'd0); chk("reset_rd_all", rd_all);
    push(64'h10); chk("dec_in_reset", {56'd0, dec_out});
    @(negedge clk); rst_n = 1; wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i); #1;
      push(64'd0); chk("dec_off", {56'd0, dec_out});
    end
    // fill: register i gets value i, checking the one-hot decode each cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); wr_en = 1; sel = 3'(i); wd = W'(i); #1;
      push(64'h1 << i); chk("dec_on", {56'd0, dec_out});
      @(posedge clk); mdl[i] = W'(i);
    end
    @(negedge clk); wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i); #1;
      push(64'(i)); chk("fill_rd", {56'd0, rd_data});
    end
    sel = 3'd3; wd = 8'hAA;
    repeat (5) @(posedge clk);
    @(negedge clk);
    push(packm()); chk("hold_all", rd_all);
    rd_sel = 3'd3; #1;
    push(64'd3); chk("hold_reg3", {56'd0, rd_data});
    @(negedge clk); wr_en = 1; sel = 3'd5; wd = 8'h55; rd_sel = 3'd5; #1;
    push(64'd5); chk("pre_edge", {56'd0, rd_data});
    @(posedge clk); mdl[5] = 8'h55; #1;
    push(64'h55); chk("post_edge", {56'd0, rd_data});
    push(packm()); chk("overwrite_all", rd_all);
    @(negedge clk); sel = 3'd7; wd = 8'h11;
    @(negedge clk); wd = 8'h22;
    @(negedge clk); sel = 3'd0; wd = 8'hFF;
    @(negedge clk); wr_en = 0; mdl[7] = 8'h22; mdl[0] = 8'hFF;
    rd_sel = 3'd7; #1;
    push(64'h22); chk("last_write", {56'd0, rd_data});
    rd_sel = 3'd0; #1;
    push(64'hFF); chk("full_width", {56'd0, rd_data});
    push(packm()); chk("after_writes", rd_all);
    @(negedge clk); #2 rst_n = 0; #1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    push(64'd0); chk("async_clear", rd_all);
    push(64'd0); chk("async_rd_data", {56'd0, rd_data});
    @(negedge clk); rst_n = 1;
    @(negedge clk); wr_en = 1; sel = 3'd2; wd = 8'h77;
    @(negedge clk); wr_en = 0; mdl[2] = 8'h77; rd_sel = 3'd2; #1;
    push(64'h77); chk("post_reset_write", {56'd0, rd_data});
    // reset asserted before the edge discards the pending write
    @(negedge clk); wr_en = 1; sel = 3'd2; wd = 8'hFF; #2 rst_n = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    push(64'd0); chk("reset_beats_write", rd_all);
    push(64'h04); chk("dec_during_reset", {56'd0, dec_out});
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1; mdl[2] = 8'hFF;
    push(64'hFF); chk("first_write_after_reset", {56'd0, rd_data});
    push(packm()); chk("final_all", rd_all);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
